// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
// Optional build macro LEADING_ZERO_BLANK_EN darkens digits above the most-significant non-zero.
module seg_scan_ctrl #(
  parameter int unsigned N_DIGITS  = 8,
  parameter int unsigned DIGIT_CYC = 100_000,
  parameter int unsigned BLANK_CYC = 2_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] data_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   digit_en,
  output logic                  load_ack,
  output logic                  frame_done,
  output logic [N_DIGITS-1:0]   an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int unsigned IdxW = $clog2(N_DIGITS);
  localparam int unsigned CntW = $clog2(DIGIT_CYC);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(N_DIGITS - 1);
  localparam logic [CntW-1:0] CntMax   = CntW'(DIGIT_CYC - 1);
  localparam logic [CntW-1:0] BlankEnd = CntW'(BLANK_CYC - 1);

  typedef enum logic [0:0] {StBlank, StShow} state_e;

  state_e                r_state;
  logic [CntW-1:0]       r_presc;
  logic [IdxW-1:0]       r_idx;
  logic [4*N_DIGITS-1:0] r_active, r_shadow;
  logic [N_DIGITS-1:0]   r_active_dp, r_shadow_dp;
  logic                  r_pending;
  logic                  r_load_ack, r_frame_done, r_dp;
  logic [N_DIGITS-1:0]   r_an;
  logic [6:0]            r_seg;

  logic                  w_wrap, w_commit, w_dark, w_show_dp;
  logic [3:0]            w_nibble;
  logic [6:0]            w_seg;
  logic [N_DIGITS-1:0]   w_show_an;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    unique case (h)
      4'h0: hex7 = 7'b0000001;
      4'h1: hex7 = 7'b1001111;
      4'h2: hex7 = 7'b0010010;
      4'h3: hex7 = 7'b0000110;
      4'h4: hex7 = 7'b1001100;
      4'h5: hex7 = 7'b0100100;
      4'h6: hex7 = 7'b0100000;
      4'h7: hex7 = 7'b0001111;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0000100;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b1100000;
      4'hC: hex7 = 7'b0110001;
      4'hD: hex7 = 7'b1000010;
      4'hE: hex7 = 7'b0110000;
      default: hex7 = 7'b0111000;
    endcase
  endfunction

  assign w_wrap   = (r_presc == CntMax);
  assign w_commit = w_wrap && (r_idx == LastIdx);
  assign w_nibble = r_active[{r_idx, 2'b00} +: 4];
  assign w_seg    = hex7(w_nibble);

`ifdef LEADING_ZERO_BLANK_EN
  logic [N_DIGITS-1:0] w_keep;
  logic                w_acc;
  // A digit stays lit if it or any digit above it is non-zero; digit 0 always lit.
  always_comb begin
    w_acc  = 1'b0;
    w_keep = '0;
    for (int i = N_DIGITS - 1; i > 0; i--) begin
      w_acc     = w_acc | (|r_active[4*i +: 4]);
      w_keep[i] = w_acc;
    end
    w_keep[0] = 1'b1;
  end
  assign w_dark = ~w_keep[r_idx];
`else
  assign w_dark = 1'b0;
`endif

  assign w_show_an = (digit_en[r_idx] && !w_dark) ?
                     ~({{(N_DIGITS-1){1'b0}}, 1'b1} << r_idx) : '1;
  assign w_show_dp = ~r_active_dp[r_idx] | w_dark;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StBlank;
      r_presc      <= '0;
      r_idx        <= '0;
      r_active     <= '0;
      r_shadow     <= '0;
      r_active_dp  <= '0;
      r_shadow_dp  <= '0;
      r_pending    <= 1'b0;
      r_load_ack   <= 1'b0;
      r_frame_done <= 1'b0;
      r_an         <= '1;
      r_seg        <= '1;
      r_dp         <= 1'b1;
    end else begin
      r_load_ack   <= 1'b0;
      r_frame_done <= w_commit;

      if (w_wrap) begin
        r_presc <= '0;
        r_idx   <= (r_idx == LastIdx) ? '0 : r_idx + 1'b1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end

      unique case (r_state)
        StBlank: begin
          r_an  <= '1;
          r_seg <= '1;
          r_dp  <= 1'b1;
          if (r_presc == BlankEnd) r_state <= StShow;
        end
        default: begin
          r_an  <= w_show_an;
          r_seg <= w_seg;
          r_dp  <= w_show_dp;
          if (w_wrap) r_state <= StBlank;
        end
      endcase

      // A load landing on the commit cycle bypasses the shadow and wins over it.
      if (w_commit && load) begin
        r_active    <= data_in;
        r_active_dp <= dp_in;
        r_pending   <= 1'b0;
        r_load_ack  <= 1'b1;
      end else if (w_commit && r_pending) begin
        r_active    <= r_shadow;
        r_active_dp <= r_shadow_dp;
        r_pending   <= 1'b0;
        r_load_ack  <= 1'b1;
      end else if (load) begin
        r_shadow    <= data_in;
        r_shadow_dp <= dp_in;
        r_pending   <= 1'b1;
      end
    end
  end

  assign load_ack   = r_load_ack;
  assign frame_done = r_frame_done;
  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;

endmodule
